// File: rtl/ps2_pkg.sv
// Shared state encoding, error codes and keyboard command bytes for the
// PS/2 host transmitter and the receiver path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    WAIT_EDGE = 3'd3,
    SHIFT     = 3'd4,
    ACK_IDLE  = 3'd5,
    FINISH    = 3'd6
  } ps2_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_FRAME_TO = 2'b10;
  localparam logic [1:0] ERR_NACK     = 2'b11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity: data bits plus parity hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the keyboard controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  modport master (output tx_data, output tx_valid, input busy, input done, input err_code);
  modport slave  (input tx_data, input tx_valid, output busy, output done, output err_code);

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus a falling-edge pulse on the
// synchronized level. Resets to the idle-high line level so reset makes no edge.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      prev_r <= RESET_VAL;
    end else begin
      meta_r <= pin;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign fall  = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, eleven
// device-clocked bits with odd parity, then ACK check. Lines are open-drain pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_low,
  output logic           ps2_dat_low
);

  // One saturating counter serves inhibit, start and frame timing, so it must hold the largest.
  localparam int MAX_A_C   = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int MAX_C     = (MAX_A_C > INHIBIT_CYCLES) ? MAX_A_C : INHIBIT_CYCLES;
  localparam int CNT_W     = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STO_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FTO_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  ps2_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0]       bit_idx_r, bit_idx_nxt_s;
  logic [7:0]       data_r, data_nxt_s;
  logic             par_r, par_nxt_s;
  logic             clk_low_r, clk_low_nxt_s;
  logic             dat_low_r, dat_low_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic [1:0]       err_code_r, err_code_nxt_s, err_nxt_s;
  logic             clk_sync_s, clk_fall_s, dat_sync_s, dat_fall_unused_s;

  ps2_sync_edge #(.RESET_VAL(1'b1)) u_clk_sync (
    .clk(CLOCK_50), .resetn(resetn), .pin(ps2_clk_in), .level(clk_sync_s), .fall(clk_fall_s)
  );

  ps2_sync_edge #(.RESET_VAL(1'b1)) u_dat_sync (
    .clk(CLOCK_50), .resetn(resetn), .pin(ps2_dat_in), .level(dat_sync_s), .fall(dat_fall_unused_s)
  );

  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);

  // Next-state, next-line and handshake decode; line enables are registered from these.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_inc_s;
    bit_idx_nxt_s = bit_idx_r;
    data_nxt_s    = data_r;
    par_nxt_s     = par_r;
    err_nxt_s     = ERR_OK;
    clk_low_nxt_s = 1'b0;
    dat_low_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (tx.tx_valid) begin
          state_nxt_s   = INHIBIT;
          data_nxt_s    = tx.tx_data;
          par_nxt_s     = odd_parity(tx.tx_data);
          clk_low_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INHIBIT: begin
        clk_low_nxt_s = 1'b1;
        if (cnt_r == INH_LAST) begin
          state_nxt_s   = REQ;
          dat_low_nxt_s = 1'b1;
        end else begin
          dat_low_nxt_s = 1'b0;
        end
      end
      REQ: begin
        state_nxt_s   = WAIT_EDGE;
        cnt_nxt_s     = {CNT_W{1'b0}};
        dat_low_nxt_s = 1'b1;
      end
      WAIT_EDGE: begin
        if (clk_fall_s) begin
          state_nxt_s   = SHIFT;
          dat_low_nxt_s = ~data_r[0];
          bit_idx_nxt_s = 4'd1;
          cnt_nxt_s     = {CNT_W{1'b0}};
        end else if (cnt_r == STO_LAST) begin
          state_nxt_s = FINISH;
          err_nxt_s   = ERR_START_TO;
        end else begin
          dat_low_nxt_s = 1'b1;
        end
      end
      SHIFT: begin
        // bit_idx counts falls already seen: 1-7 data, 8 parity, 9 stop, 10 ACK sample.
        if (clk_fall_s) begin
          bit_idx_nxt_s = bit_idx_r + 4'd1;
          if (bit_idx_r <= 4'd7) begin
            dat_low_nxt_s = ~data_r[bit_idx_r[2:0]];
          end else if (bit_idx_r == 4'd8) begin
            dat_low_nxt_s = ~par_r;
          end else if (bit_idx_r == 4'd9) begin
            dat_low_nxt_s = 1'b0;
          end else if (dat_sync_s) begin
            state_nxt_s = FINISH;
            err_nxt_s   = ERR_NACK;
          end else begin
            state_nxt_s = ACK_IDLE;
          end
        end else if (cnt_r == FTO_LAST) begin
          state_nxt_s = FINISH;
          err_nxt_s   = ERR_FRAME_TO;
        end else begin
          dat_low_nxt_s = dat_low_r;
        end
      end
      ACK_IDLE: begin
        if (clk_sync_s && dat_sync_s) begin
          state_nxt_s = FINISH;
          err_nxt_s   = ERR_OK;
        end else if (cnt_r == FTO_LAST) begin
          state_nxt_s = FINISH;
          err_nxt_s   = ERR_FRAME_TO;
        end else begin
          state_nxt_s = ACK_IDLE;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s     = (state_nxt_s != IDLE);
    done_nxt_s     = (state_nxt_s == FINISH);
    err_code_nxt_s = done_nxt_s ? err_nxt_s : err_code_r;
  end

  // State, datapath and registered outputs; reset releases both lines at once.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_idx_r  <= 4'd0;
      data_r     <= 8'h00;
      par_r      <= 1'b0;
      clk_low_r  <= 1'b0;
      dat_low_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_code_r <= ERR_OK;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      data_r     <= data_nxt_s;
      par_r      <= par_nxt_s;
      clk_low_r  <= clk_low_nxt_s;
      dat_low_r  <= dat_low_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      err_code_r <= err_code_nxt_s;
    end
  end

  assign ps2_clk_low = clk_low_r;
  assign ps2_dat_low = dat_low_r;
  assign tx.busy     = busy_r;
  assign tx.done     = done_r;
  assign tx.err_code = err_code_r;

endmodule
